// File: rtl/prbs_pkg.sv
// prbs_pkg: definitions shared by the PRBS generator and checker.
// Holds the checker FSM state type, the LFSR tap/seed constants and the
// single-step LFSR function (x^8+x^6+x^5+x^4+1).
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } prbsState_e;

  // Feedback taps at bits 7, 5, 4 and 3.
  localparam logic [7:0] PRBS_TAPS = 8'hB8;
  localparam logic [7:0] PRBS_SEED = 8'h01;

  // One LFSR step: shift left, feed the tap parity into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// prbs_lfsr_step: purely combinational single LFSR advance, 8 bits in, 8 out.
module prbs_lfsr_step
  import prbs_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = lfsr_next(cur);

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: locks onto an 8-bit PRBS byte stream and counts errors.
// Lock is declared after a seeding byte followed by LOCK_COUNT consecutive
// matching bytes; LOSS_COUNT consecutive mismatches while locked drop back to
// SYNC and reseed from the current byte.
// Optional build macro PRBS_CHECKER_BITERR_EN: the error counter accumulates
// the number of wrong bits per mismatching byte instead of one per byte.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic       PRBS_CHECKER_CLOCK_50,
  input  logic       PRBS_CHECKER_RESET_InLow,
  input  logic       PRBS_CHECKER_clear_InLow,
  input  logic       PRBS_CHECKER_valid_InLow,
  input  logic [7:0] PRBS_CHECKER_data_InBUS,
  output logic       PRBS_CHECKER_locked_Out,
  output logic       PRBS_CHECKER_error_Out,
  output logic [7:0] PRBS_CHECKER_errcnt_OutBUS
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int MW = (LOSS_COUNT < 2) ? 1 : $clog2(LOSS_COUNT);
  localparam logic [CW-1:0] LOCK_LIM  = CW'(LOCK_COUNT);
  localparam logic [MW-1:0] LOSS_LAST = MW'(LOSS_COUNT - 1);

  prbsState_e    stateReg, stateNext;
  logic [7:0]    expReg, expNext;
  logic [CW-1:0] matchReg, matchNext;
  logic [MW-1:0] missReg, missNext;
  logic [7:0]    errcntReg, errcntNext;
  logic          lockedReg, errorReg, errPulseNext;

  logic [7:0]    seedNext, advNext, errInc, errSat;
  logic [8:0]    errSum;
  logic          isMatch, dataZero;

  // Seeding path steps the received byte, advance path steps the expectation.
  prbs_lfsr_step seedStep (.cur(PRBS_CHECKER_data_InBUS), .nxt(seedNext));
  prbs_lfsr_step advStep  (.cur(expReg),                  .nxt(advNext));

  assign isMatch  = (PRBS_CHECKER_data_InBUS == expReg);
  assign dataZero = (PRBS_CHECKER_data_InBUS == 8'h00);

`ifdef PRBS_CHECKER_BITERR_EN
  logic [7:0] diffBits;
  assign diffBits = PRBS_CHECKER_data_InBUS ^ expReg;
  // Count the wrong bits in the current byte.
  always_comb begin
    errInc = 8'd0;
    for (int i = 0; i < 8; i++) begin
      errInc = errInc + {7'd0, diffBits[i]};
    end
  end
`else
  assign errInc = 8'd1;
`endif

  assign errSum = {1'b0, errcntReg} + {1'b0, errInc};
  assign errSat = errSum[8] ? 8'hFF : errSum[7:0];

  // Next-state, expectation, counters and error pulse for the sampled byte.
  always_comb begin
    stateNext    = stateReg;
    expNext      = expReg;
    matchNext    = matchReg;
    missNext     = missReg;
    errcntNext   = errcntReg;
    errPulseNext = 1'b0;
    if (!PRBS_CHECKER_clear_InLow) begin
      stateNext  = IDLE;
      expNext    = PRBS_SEED;
      matchNext  = '0;
      missNext   = '0;
      errcntNext = 8'd0;
    end else if (!PRBS_CHECKER_valid_InLow) begin
      case (stateReg)
        IDLE: begin
          // 0x00 is the LFSR lock-up state and can never seed.
          if (!dataZero) begin
            stateNext = SYNC;
            expNext   = seedNext;
            matchNext = CW'(1);
          end
        end
        SYNC: begin
          if (isMatch) begin
            expNext = advNext;
            if (matchReg == LOCK_LIM) begin
              stateNext = LOCKED;
              matchNext = '0;
              missNext  = '0;
            end else begin
              matchNext = matchReg + CW'(1);
            end
          end else if (!dataZero) begin
            expNext   = seedNext;
            matchNext = CW'(1);
          end else begin
            stateNext = IDLE;
            matchNext = '0;
          end
        end
        LOCKED: begin
          expNext = advNext;
          if (isMatch) begin
            missNext = '0;
          end else begin
            errPulseNext = 1'b1;
            errcntNext   = errSat;
            if (missReg == LOSS_LAST) begin
              // Lock lost: reseed from this byte exactly as SYNC would.
              missNext = '0;
              if (!dataZero) begin
                stateNext = SYNC;
                expNext   = seedNext;
                matchNext = CW'(1);
              end else begin
                stateNext = IDLE;
                matchNext = '0;
              end
            end else begin
              missNext = missReg + MW'(1);
            end
          end
        end
        default: begin
          stateNext = IDLE;
          matchNext = '0;
          missNext  = '0;
        end
      endcase
    end
  end

  // State and registered outputs; reset acts immediately, independent of clock.
  always_ff @(posedge PRBS_CHECKER_CLOCK_50 or negedge PRBS_CHECKER_RESET_InLow) begin
    if (!PRBS_CHECKER_RESET_InLow) begin
      stateReg  <= IDLE;
      expReg    <= PRBS_SEED;
      matchReg  <= '0;
      missReg   <= '0;
      errcntReg <= 8'd0;
      lockedReg <= 1'b0;
      errorReg  <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      expReg    <= expNext;
      matchReg  <= matchNext;
      missReg   <= missNext;
      errcntReg <= errcntNext;
      lockedReg <= (stateNext == LOCKED);
      errorReg  <= errPulseNext;
    end
  end

  assign PRBS_CHECKER_locked_Out    = lockedReg;
  assign PRBS_CHECKER_error_Out     = errorReg;
  assign PRBS_CHECKER_errcnt_OutBUS = errcntReg;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed self-checking bench for prbs_checker.
// Reference sequence from seed 0x01:
// 01 02 04 08 11 23 47 8E 1C 38 71 E2 C4 89 12 25 4B 97 2E 5C
// Expected error counts follow PRBS_CHECKER_BITERR_EN when it is defined.
module tb_prbs_checker;

`ifdef PRBS_CHECKER_BITERR_EN
  localparam bit BITERR = 1'b1;
`else
  localparam bit BITERR = 1'b0;
`endif

  logic       clk;
  logic       rstN;
  logic       clearN;
  logic       validN;
  logic [7:0] data;
  logic       locked;
  logic       errPulse;
  logic [7:0] errcnt;

  int checkCnt = 0;
  int errorCnt = 0;

  prbs_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
    .PRBS_CHECKER_CLOCK_50     (clk),
    .PRBS_CHECKER_RESET_InLow  (rstN),
    .PRBS_CHECKER_clear_InLow  (clearN),
    .PRBS_CHECKER_valid_InLow  (validN),
    .PRBS_CHECKER_data_InBUS   (data),
    .PRBS_CHECKER_locked_Out   (locked),
    .PRBS_CHECKER_error_Out    (errPulse),
    .PRBS_CHECKER_errcnt_OutBUS(errcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference step: taps 7,5,4,3 written out explicitly.
  function automatic logic [7:0] refNext(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] want);
    checkCnt++;
    if (got !== want) begin
      errorCnt++;
      $display("FAIL %s got=0x%02h want=0x%02h", tag, got, want);
    end
  endtask

  // Present one valid byte for one clock; outputs are sampled 1 ns after the edge.
  task automatic sendByte(input logic [7:0] b);
    validN = 1'b0;
    data   = b;
    @(posedge clk);
    #1;
    validN = 1'b1;
    $display("byte 0x%02h -> locked=%0b error=%0b errcnt=0x%02h", b, locked, errPulse, errcnt);
  endtask

  task automatic idleCycle();
    validN = 1'b1;
    @(posedge clk);
    #1;
    $display("idle -> locked=%0b error=%0b errcnt=0x%02h", locked, errPulse, errcnt);
  endtask

  task automatic clearWith(input logic [7:0] b);
    clearN = 1'b0;
    validN = 1'b0;
    data   = b;
    @(posedge clk);
    #1;
    clearN = 1'b1;
    validN = 1'b1;
    $display("clear+byte 0x%02h -> locked=%0b error=%0b errcnt=0x%02h", b, locked, errPulse, errcnt);
  endtask

  task automatic lockFromSeed();
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h04);
    sendByte(8'h08);
    checkEq("nolock_after_08", {7'd0, locked}, 8'd0);
    sendByte(8'h11);
    checkEq("lock_after_11", {7'd0, locked}, 8'd1);
  endtask

  initial begin
    logic [7:0] exp;
    int         expErr;
    rstN   = 1'b0;
    clearN = 1'b1;
    validN = 1'b1;
    data   = 8'h00;
    #12;
    checkEq("reset_locked", {7'd0, locked}, 8'd0);
    checkEq("reset_error", {7'd0, errPulse}, 8'd0);
    checkEq("reset_errcnt", errcnt, 8'h00);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Lock on 01 02 04 08 11.
    sendByte(8'h01);
    checkEq("sync_01_locked", {7'd0, locked}, 8'd0);
    sendByte(8'h02);
    sendByte(8'h04);
    sendByte(8'h08);
    checkEq("sync_08_locked", {7'd0, locked}, 8'd0);
    sendByte(8'h11);
    checkEq("lock_locked", {7'd0, locked}, 8'd1);
    checkEq("lock_errcnt", errcnt, 8'h00);
    checkEq("lock_error", {7'd0, errPulse}, 8'd0);

    // Single bad byte 0x00 in place of 0x23, then resume.
    sendByte(8'h00);
    checkEq("single_err_pulse", {7'd0, errPulse}, 8'd1);
    checkEq("single_err_cnt", errcnt, BITERR ? 8'd3 : 8'd1);
    checkEq("single_err_locked", {7'd0, locked}, 8'd1);
    sendByte(8'h47);
    checkEq("resume_pulse", {7'd0, errPulse}, 8'd0);
    checkEq("resume_locked", {7'd0, locked}, 8'd1);
    sendByte(8'h8E);

    // Invalid cycle holds everything: expectation stays at 0x1C.
    idleCycle();
    checkEq("hold_error", {7'd0, errPulse}, 8'd0);
    checkEq("hold_locked", {7'd0, locked}, 8'd1);
    sendByte(8'h1C);
    checkEq("hold_then_match_pulse", {7'd0, errPulse}, 8'd0);
    checkEq("hold_then_match_cnt", errcnt, BITERR ? 8'd3 : 8'd1);

    // Clear with a simultaneous mismatching byte while locked.
    clearWith(8'h55);
    checkEq("clear_locked", {7'd0, locked}, 8'd0);
    checkEq("clear_errcnt", errcnt, 8'h00);
    checkEq("clear_error", {7'd0, errPulse}, 8'd0);

    // Three consecutive wrong bytes lose lock; relock on four good ones.
    lockFromSeed();
    sendByte(8'h00);
    checkEq("loss1_cnt", errcnt, BITERR ? 8'd3 : 8'd1);
    checkEq("loss1_locked", {7'd0, locked}, 8'd1);
    sendByte(8'h00);
    checkEq("loss2_cnt", errcnt, BITERR ? 8'd7 : 8'd2);
    checkEq("loss2_locked", {7'd0, locked}, 8'd1);
    sendByte(8'h01);
    checkEq("loss3_cnt", errcnt, BITERR ? 8'd12 : 8'd3);
    checkEq("loss3_pulse", {7'd0, errPulse}, 8'd1);
    checkEq("loss3_locked", {7'd0, locked}, 8'd0);
    sendByte(8'h02);
    sendByte(8'h04);
    sendByte(8'h08);
    checkEq("relock_08_locked", {7'd0, locked}, 8'd0);
    sendByte(8'h11);
    checkEq("relock_11_locked", {7'd0, locked}, 8'd1);
    checkEq("relock_cnt", errcnt, BITERR ? 8'd12 : 8'd3);

    // Saturation: alternate a 1-bit error with a correct byte until 0xFF.
    exp    = 8'h23;
    expErr = BITERR ? 12 : 3;
    for (int i = 0; i < 400 && expErr < 255; i++) begin
      sendByte(exp ^ 8'h01);
      expErr = expErr + 1;
      exp    = refNext(exp);
      sendByte(exp);
      exp    = refNext(exp);
    end
    checkEq("sat_reach_cnt", errcnt, 8'hFF);
    checkEq("sat_reach_locked", {7'd0, locked}, 8'd1);
    sendByte(exp ^ 8'h80);
    checkEq("sat_hold_cnt", errcnt, 8'hFF);
    checkEq("sat_hold_pulse", {7'd0, errPulse}, 8'd1);

    // Byte 0x5C in place of 0x23: 7 differing bits.
    clearWith(8'h23);
    checkEq("clear2_errcnt", errcnt, 8'h00);
    lockFromSeed();
    sendByte(8'h5C);
    checkEq("bits_5c_cnt", errcnt, BITERR ? 8'd7 : 8'd1);
    checkEq("bits_5c_pulse", {7'd0, errPulse}, 8'd1);

    // Reset between clock edges while locked: outputs drop at once.
    #3;
    rstN = 1'b0;
    #1;
    checkEq("async_rst_locked", {7'd0, locked}, 8'd0);
    checkEq("async_rst_error", {7'd0, errPulse}, 8'd0);
    checkEq("async_rst_errcnt", errcnt, 8'h00);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    $display("reset pulse done -> locked=%0b errcnt=0x%02h", locked, errcnt);

    // After reset a zero byte is ignored and lock needs a full fresh run.
    sendByte(8'h00);
    checkEq("post_rst_zero_locked", {7'd0, locked}, 8'd0);
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h04);
    sendByte(8'h08);
    checkEq("post_rst_08_locked", {7'd0, locked}, 8'd0);
    sendByte(8'h11);
    checkEq("post_rst_11_locked", {7'd0, locked}, 8'd1);
    checkEq("post_rst_errcnt", errcnt, 8'h00);

    $display("Result: errors=%0d of %0d checks", errorCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive matching bytes needed to declare lock.
REQ-002 SHALL have parameter LOSS_COUNT, default 3: consecutive mismatching bytes while locked that declare loss of lock.
REQ-003 SHALL have port PRBS_CHECKER_CLOCK_50  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port PRBS_CHECKER_RESET_InLow  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port PRBS_CHECKER_clear_InLow  input  1  synchronous clear, active-low.
REQ-006 SHALL have port PRBS_CHECKER_valid_InLow  input  1  byte strobe, active-low; the data byte is sampled only when this is 0.
REQ-007 SHALL have port PRBS_CHECKER_data_InBUS  input  8  received PRBS byte.
REQ-008 SHALL have port PRBS_CHECKER_locked_Out  output  1  high while in LOCKED.
REQ-009 SHALL have port PRBS_CHECKER_error_Out  output  1  one-cycle pulse on each mismatch counted in LOCKED.
REQ-010 SHALL have port PRBS_CHECKER_errcnt_OutBUS  output  8  saturating error count.

Function
REQ-011 SHALL use the generator's sequence: next(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]} (x^8+x^6+x^5+x^4+1), one step per valid byte.
REQ-012 SHALL register every output, so each output updates one cycle after the sampling edge.
REQ-013 SHALL implement FSM states IDLE, SYNC, LOCKED.
REQ-014 In IDLE, a valid nonzero byte B SHALL load expected <= next(B), set match count to 1 and go to SYNC; a valid 0x00 byte SHALL be ignored because 0x00 is the lock-up state.
REQ-015 In SYNC, a valid byte equal to expected SHALL increment the match count; when the count reaches LOCK_COUNT the FSM SHALL enter LOCKED.
REQ-016 In SYNC, a valid byte not equal to expected SHALL reseed: when nonzero, expected <= next(byte) and count = 1; when 0x00, the FSM SHALL return to IDLE.
REQ-017 In LOCKED, every valid byte SHALL advance expected <= next(expected), never reseeding from data.
REQ-018 In LOCKED, a mismatch SHALL pulse error_Out, increment errcnt (saturating at 0xFF) and increment the miss count; a match SHALL zero the miss count.
REQ-019 When the miss count reaches LOSS_COUNT, the FSM SHALL go to SYNC and reseed from the current byte per REQ-016.
REQ-020 Errors SHALL never be counted in IDLE or SYNC.
REQ-021 When valid_InLow is 1, state, expected value and counts SHALL hold, and error_Out SHALL be 0.
REQ-022 clear_InLow = 0 SHALL override a simultaneous valid byte: FSM to IDLE, all counts and errcnt to 0, outputs low on the next cycle.

Reset
REQ-023 Assertion of RESET_InLow = 0 SHALL immediately force the FSM to IDLE, expected to 0x01, all counts to 0, locked_Out = 0, error_Out = 0 and errcnt_OutBUS = 0x00, regardless of the clock.
REQ-024 Reset asserted mid-lock SHALL discard lock; after release, relock SHALL require a fresh LOCK_COUNT matches.

Configuration
REQ-025 Macro PRBS_CHECKER_BITERR_EN defined: errcnt SHALL add popcount(byte XOR expected) per mismatch, saturating at 0xFF.
REQ-026 Macro PRBS_CHECKER_BITERR_EN undefined: errcnt SHALL add 1 per mismatched byte, and no popcount logic SHALL be present.

Structure
REQ-027 Package prbs_pkg SHALL hold the FSM state typedef, the tap constants and the lfsr_next function, all shared with the generator.
REQ-028 Sub-module prbs_lfsr_step (combinational next-state, 8 bits in, 8 bits out) SHALL be instantiated for both the seeding path and the advance path.

Verification
REQ-029 Reset, then valid bytes 0x01,0x02,0x04,0x08,0x11 -> locked_Out = 1 one cycle after the 4th match (0x11), errcnt = 0.
REQ-030 Locked, then send 0x00 in place of the expected 0x23, then resume the correct sequence -> one error pulse, errcnt = 1, locked stays 1.
REQ-031 Locked, then 3 consecutive wrong bytes -> errcnt = 3, locked_Out falls after the 3rd, relock after 4 correct bytes.
REQ-032 Locked with errcnt = 0xFF, then a further mismatch -> errcnt stays 0xFF.
REQ-033 Clear asserted together with a valid byte while locked -> locked = 0, errcnt = 0 next cycle; reset pulse asserted between clock edges -> outputs zero immediately.
REQ-034 With BITERR_EN, locked, send 0x5C instead of the expected 0x23 -> errcnt = 7.
